// File: rtl/shared_mem_responder_pkg.sv
// Shared definitions for the shared-memory responder.
//   port_w()    : width of an encoded requester index (at least 1 bit)
//   tag_t       : read-tag entry {valid, port} for the default configuration
//   DEF_*       : default parameter values
package shared_mem_responder_pkg;

    localparam int DEF_REQ_WIDTH  = 10;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_RD_LATENCY = 2;

    // ceil(log2(n)), with a one-bit floor so a single-port build still
    // has a legal port field.
    function automatic int port_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_PORT_W = port_w(DEF_REQ_WIDTH);

    typedef struct packed {
        logic                  valid;
        logic [DEF_PORT_W-1:0] port;
    } tag_t;

endpackage

// File: rtl/shared_mem_responder_tag_pipe.sv
// resp_tag_pipe: fixed-depth shift register of read tags.
//   clk  : clock
//   clr  : synchronous clear of every stage (valid bits drop to 0)
//   din  : tag entering stage 0 each cycle
//   dout : tag leaving the last stage (DEPTH cycles after entry)
module resp_tag_pipe
    import shared_mem_responder_pkg::*;
#(
    parameter int  DEPTH = DEF_RD_LATENCY + 1,
    parameter type entry_t = tag_t
) (
    input  logic   clk,
    input  logic   clr,
    input  entry_t din,
    output entry_t dout
);

    entry_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/shared_mem_responder.sv
// shared_mem_responder: turns an arbiter grant into a single-port SRAM
// access and routes the read data / write acknowledge back to the
// granted requester. One access per cycle, no stalls.
//   clk, rst          : clock, synchronous active-high reset
//   gnt               : arbiter grant (one-hot or zero)
//   req_we/addr/wdata : per-port request fields, port i at slice i
//   mem_*             : SRAM strobe, write enable, address, data in/out
//   resp_valid        : one-hot read response, resp_rdata shared data
//   wr_ack            : one-hot write completion
//   err_multi_gnt     : sticky multi-hot grant flag
// Build option GNT_ONEHOT_CHECK_EN: reject multi-hot grants and flag them;
// otherwise the lowest granted port is served and the flag is tied low.
module shared_mem_responder
    import shared_mem_responder_pkg::*;
#(
    parameter int REQ_WIDTH  = DEF_REQ_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [REQ_WIDTH-1:0]             gnt,
    input  logic [REQ_WIDTH-1:0]             req_we,
    input  logic [REQ_WIDTH*ADDR_WIDTH-1:0]  req_addr,
    input  logic [REQ_WIDTH*DATA_WIDTH-1:0]  req_wdata,
    output logic                             mem_en,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    output logic [REQ_WIDTH-1:0]             resp_valid,
    output logic [DATA_WIDTH-1:0]            resp_rdata,
    output logic [REQ_WIDTH-1:0]             wr_ack,
    output logic                             err_multi_gnt
);

    localparam int PORT_W = port_w(REQ_WIDTH);

    typedef struct packed {
        logic              valid;
        logic [PORT_W-1:0] port;
    } tag_entry_t;

    logic                  sel_any;
    logic                  sel_we;
    logic [PORT_W-1:0]     sel_idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  accept;
    tag_entry_t            tag_in;
    tag_entry_t            tag_out;
    logic [REQ_WIDTH-1:0]  resp_dec;
    logic [REQ_WIDTH-1:0]  ack_dec;

    // Priority select: scanning downward lets the lowest set bit win.
    always_comb begin
        sel_any   = 1'b0;
        sel_we    = 1'b0;
        sel_idx   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = REQ_WIDTH - 1; i >= 0; i--) begin
            if (gnt[i]) begin
                sel_any   = 1'b1;
                sel_we    = req_we[i];
                sel_idx   = PORT_W'(i);
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef GNT_ONEHOT_CHECK_EN
    logic multi_hot;
    logic err_q;

    // x & (x-1) clears the lowest set bit; anything left means >1 bit set.
    assign multi_hot = |(gnt & (gnt - REQ_WIDTH'(1)));
    assign accept    = sel_any & ~multi_hot;

    always_ff @(posedge clk) begin
        if (rst)            err_q <= 1'b0;
        else if (multi_hot) err_q <= 1'b1;
    end

    assign err_multi_gnt = err_q;
`else
    assign accept        = sel_any;
    assign err_multi_gnt = 1'b0;
`endif

    // Only reads carry a tag; writes complete immediately via wr_ack.
    assign tag_in.valid = accept & ~sel_we;
    assign tag_in.port  = sel_idx;

    // Stage 0 lines up with the mem_en cycle, so the last stage lines up
    // with mem_rdata valid and resp_* are registered one cycle later.
    resp_tag_pipe #(
        .DEPTH   (RD_LATENCY + 1),
        .entry_t (tag_entry_t)
    ) u_tag_pipe (
        .clk  (clk),
        .clr  (rst),
        .din  (tag_in),
        .dout (tag_out)
    );

    always_comb begin
        resp_dec = '0;
        ack_dec  = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            resp_dec[i] = tag_out.valid && (tag_out.port == PORT_W'(i));
            ack_dec[i]  = accept && sel_we && (sel_idx == PORT_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
            wr_ack     <= '0;
        end else begin
            mem_en     <= accept;
            wr_ack     <= ack_dec;
            resp_valid <= resp_dec;
            // Address/data/we hold across idle cycles.
            if (accept) begin
                mem_we    <= sel_we;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
            if (tag_out.valid) resp_rdata <= mem_rdata;
        end
    end

endmodule

// File: doc/shared_mem_responder.md
SHARED_MEM_RESPONDER -- requirements
Module: shared_mem_responder

Interface
REQ-001 Parameter REQ_WIDTH, default 10, SHALL set the number of requester ports, matching the round-robin arbiter width.
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL set the shared-memory word address width.
REQ-003 Parameter DATA_WIDTH, default 32, SHALL set the data word width.
REQ-004 Parameter RD_LATENCY, default 2 (legal range 1..4), SHALL set the SRAM read latency in cycles from mem_en sampled to mem_rdata valid.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 gnt  in  REQ_WIDTH  grant vector from the arbiter, one-hot or zero.
REQ-008 req_we  in  REQ_WIDTH  per-port write enable (1 = write, 0 = read).
REQ-009 req_addr  in  REQ_WIDTH*ADDR_WIDTH  per-port address, port i at slice i.
REQ-010 req_wdata  in  REQ_WIDTH*DATA_WIDTH  per-port write data, port i at slice i.
REQ-011 mem_en / mem_we  out  1 / 1  SRAM access strobe and write enable.
REQ-012 mem_addr / mem_wdata  out  ADDR_WIDTH / DATA_WIDTH  SRAM address and write data.
REQ-013 mem_rdata  in  DATA_WIDTH  SRAM read data.
REQ-014 resp_valid  out  REQ_WIDTH  one-hot read-response strobe to the originating port.
REQ-015 resp_rdata  out  DATA_WIDTH  read data shared by all ports, qualified by resp_valid.
REQ-016 wr_ack  out  REQ_WIDTH  one-hot write-completion strobe.
REQ-017 err_multi_gnt  out  1  sticky flag: a multi-hot gnt was received.

Function
REQ-018 Cycle N, gnt one-hot on port p: the block SHALL select port p's req_we, addr and wdata and register them onto mem_* at cycle N+1, with mem_en=1.
REQ-019 gnt all-zero: mem_en SHALL be 0 at N+1; mem_addr, mem_wdata and mem_we SHALL hold their previous values.
REQ-020 Write grant at N: mem_we=1 at N+1; wr_ack[p] SHALL pulse for exactly one cycle at N+1; no resp_valid is issued.
REQ-021 Read grant at N: the block SHALL push {valid=1, port=p} into a tag shift pipeline of depth RD_LATENCY+1; at N+2+RD_LATENCY it SHALL assert resp_valid[p] for one cycle, with resp_rdata registered from mem_rdata.
REQ-022 Throughput SHALL be one access per cycle; back-to-back reads from different ports SHALL return in issue order, each on its own port.
REQ-023 Mixed read and write streams SHALL not stall; a write issued while reads are in flight SHALL not disturb their tags.
REQ-024 resp_rdata SHALL hold its last value when no response is valid.
REQ-025 At most one bit of resp_valid and at most one bit of wr_ack SHALL be set in any cycle.
REQ-026 Port index encoding SHALL use ceil(log2(REQ_WIDTH)) bits; wrap of port index is not permitted (the encoder covers only 0..REQ_WIDTH-1).

Reset
REQ-027 With rst=1 at a rising edge: mem_en, mem_we, resp_valid, wr_ack and err_multi_gnt SHALL be 0; mem_addr, mem_wdata and resp_rdata SHALL be 0; all tag-pipeline valid bits SHALL be 0.
REQ-028 Reset mid-operation SHALL flush in-flight reads; no resp_valid SHALL appear for grants accepted before reset.
REQ-029 Grants presented while rst=1 SHALL be ignored.

Configuration
REQ-030 Macro GNT_ONEHOT_CHECK_EN defined: a multi-hot gnt SHALL produce no memory access (mem_en=0 next cycle) and SHALL set err_multi_gnt, which holds until reset.
REQ-031 Macro undefined: err_multi_gnt SHALL be tied 0, and a multi-hot gnt SHALL be served as the lowest set index.

Structure
REQ-032 A shared package SHALL hold the port-index width function, the tag-entry typedef {valid, port}, and default parameter constants.
REQ-033 One sub-module, resp_tag_pipe (a parameterised-depth shift register of tag entries with synchronous clear), SHALL be instantiated.

Verification (REQ_WIDTH=10, RD_LATENCY=2)
REQ-034 Read: gnt=10'b0000000100, addr[2]=0x05, mem model holds 0xA5 at 0x05, grant at cycle 0 -> mem_en=1 and mem_addr=0x05 at cycle 1; resp_valid=10'b0000000100 and resp_rdata=0xA5 at cycle 4.
REQ-035 Write: gnt=10'b1000000000, we[9]=1, addr=0x10, wdata=0xDEAD -> mem_we=1, mem_addr=0x10 and wr_ack[9]=1 at cycle 1; a later read of 0x10 returns 0xDEAD.
REQ-036 Reads granted to ports 0, 1, 2, 3 on consecutive cycles 0-3 -> resp_valid on ports 0, 1, 2, 3 in order on cycles 4-7 with the correct data.
REQ-037 Read granted at cycle 0, rst=1 at cycle 2 -> no resp_valid at any later cycle; all outputs 0 at cycle 3.
REQ-038 gnt=10'b0000000011 -> with GNT_ONEHOT_CHECK_EN: mem_en=0 and err_multi_gnt=1, sticky until reset; without it: port 0 is served and err_multi_gnt=0.
REQ-039 gnt=0 for 5 cycles -> mem_en, resp_valid and wr_ack all 0; mem_addr unchanged.
